// File: rtl/interp_add1_seq_if.sv
// Handshake and mux-side bundle of the adder-1 sequencer.
// master = sequencer view, slave = surrounding datapath view.
interface interp_add1_seq_if #(
  parameter int IN_WIDTH  = 17,
  parameter int OUT_WIDTH = 19
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [IN_WIDTH-1:0]  E1_in;
  logic signed [IN_WIDTH-1:0]  E3_in;
  logic signed [IN_WIDTH-1:0]  E4_in;
  logic [2:0]                  sel;
  logic signed [IN_WIDTH-1:0]  E1;
  logic signed [IN_WIDTH-1:0]  E3;
  logic signed [IN_WIDTH-1:0]  E4;
  logic signed [IN_WIDTH:0]    reg_2E;
  logic signed [OUT_WIDTH-1:0] reg_5E;
  logic signed [OUT_WIDTH-1:0] add1_b;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic [1:0]                  out_idx;
  logic                        out_last;
  logic                        out_valid;
  logic                        out_ready;
  logic                        sat_flag;

  modport master (
    input  in_valid, E1_in, E3_in, E4_in,
    input  add1_b, out_ready,
    output in_ready, sel, E1, E3, E4,
    output reg_2E, reg_5E,
    output out_data, out_idx, out_last,
    output out_valid, sat_flag
  );

  modport slave (
    output in_valid, E1_in, E3_in, E4_in,
    output add1_b, out_ready,
    input  in_ready, sel, E1, E3, E4,
    input  reg_2E, reg_5E,
    input  out_data, out_idx, out_last,
    input  out_valid, sat_flag
  );
endinterface

// File: rtl/interp_add1_seq.sv
// Adder-1 sequencer/accumulator of the channel-estimation interpolator.
// Define INTERP_SAT_EN for saturating reduction and a live sat_flag.
module interp_add1_seq #(
  parameter int IN_WIDTH  = 17,
  parameter int OUT_WIDTH = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  interp_add1_seq_if.master bus
);
  localparam int W  = OUT_WIDTH;
  localparam int WS = OUT_WIDTH + 1;
  localparam int W2 = IN_WIDTH + 1;

  localparam logic [2:0] SEL_IDLE = 3'b111;
  localparam logic [2:0] SEL_NEG  = 3'b001;
  localparam logic [2:0] SEL_FIVE = 3'b110;
  localparam logic [2:0] SEL_R0   = 3'b100;
  localparam logic [2:0] SEL_R1   = 3'b011;
  localparam logic [2:0] SEL_R2   = 3'b000;

  typedef enum logic [2:0] {
    IDLE, NEG, FIVE, R0, R1, R2
  } state_t;

  state_t                     r_state;
  logic [2:0]                 r_sel;
  logic signed [IN_WIDTH-1:0] r_e1;
  logic signed [IN_WIDTH-1:0] r_e3;
  logic signed [IN_WIDTH-1:0] r_e4;
  logic signed [W2-1:0]       r_2e;
  logic signed [W-1:0]        r_5e;
  logic signed [W-1:0]        r_data;
  logic [1:0]                 r_idx;
  logic                       r_last;
  logic                       r_valid;
  logic                       r_sat;

  logic signed [W-1:0]        w_a;
  logic signed [W-1:0]        w_res5;
  logic signed [W2-1:0]       w_res2;
  logic                       w_ovf5;
  logic                       w_ovf2;
  logic                       w_load;

  assign w_load = !r_valid || bus.out_ready;

  // operand a selected by the sequencing state
  always_comb begin
    w_a = '0;
    unique case (r_state)
      FIVE:    w_a = W'(r_e1) <<< 2;
      R0:      w_a = r_5e;
      R1, R2:  w_a = r_data;
      default: w_a = '0;
    endcase
  end

`ifdef INTERP_SAT_EN
  logic signed [WS-1:0] w_sum;

  // widened add (subtract in NEG), then clip to target width
  always_comb begin
    if (r_state == NEG)
      w_sum = WS'(w_a) - WS'(bus.add1_b);
    else
      w_sum = WS'(w_a) + WS'(bus.add1_b);
    w_ovf5 = w_sum[WS-1:W-1]
          != {(WS-W+1){w_sum[WS-1]}};
    w_ovf2 = w_sum[WS-1:W2-1]
          != {(WS-W2+1){w_sum[WS-1]}};
    w_res5 = w_ovf5
      ? {w_sum[WS-1], {(W-1){~w_sum[WS-1]}}}
      : w_sum[W-1:0];
    w_res2 = w_ovf2
      ? {w_sum[WS-1], {(W2-1){~w_sum[WS-1]}}}
      : w_sum[W2-1:0];
  end
`else
  // wrapping reduction keeps only the low bits
  always_comb begin
    w_res5 = w_a + bus.add1_b;
    w_res2 = -bus.add1_b[W2-1:0];
    w_ovf5 = 1'b0;
    w_ovf2 = 1'b0;
  end
`endif

  // sequencer FSM with registered mux select and results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= SEL_IDLE;
      r_e1    <= '0;
      r_e3    <= '0;
      r_e4    <= '0;
      r_2e    <= '0;
      r_5e    <= '0;
      r_data  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      if (r_valid && bus.out_ready)
        r_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_e1    <= bus.E1_in;
            r_e3    <= bus.E3_in;
            r_e4    <= bus.E4_in;
            r_sat   <= 1'b0;
            r_state <= NEG;
            r_sel   <= SEL_NEG;
          end
        end
        NEG: begin
          r_2e    <= w_res2;
          r_sat   <= r_sat | w_ovf2;
          r_state <= FIVE;
          r_sel   <= SEL_FIVE;
        end
        FIVE: begin
          r_5e    <= w_res5;
          r_sat   <= r_sat | w_ovf5;
          r_state <= R0;
          r_sel   <= SEL_R0;
        end
        R0, R1, R2: begin
          if (w_load) begin
            r_data  <= w_res5;
            r_valid <= 1'b1;
            r_sat   <= r_sat | w_ovf5;
            if (r_state == R0) begin
              r_idx   <= 2'd0;
              r_last  <= 1'b0;
              r_state <= R1;
              r_sel   <= SEL_R1;
            end else if (r_state == R1) begin
              r_idx   <= 2'd1;
              r_last  <= 1'b0;
              r_state <= R2;
              r_sel   <= SEL_R2;
            end else begin
              r_idx   <= 2'd2;
              r_last  <= 1'b1;
              r_state <= IDLE;
              r_sel   <= SEL_IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_sel   <= SEL_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.sel       = r_sel;
  assign bus.E1        = r_e1;
  assign bus.E3        = r_e3;
  assign bus.E4        = r_e4;
  assign bus.reg_2E    = r_2e;
  assign bus.reg_5E    = r_5e;
  assign bus.out_data  = r_data;
  assign bus.out_idx   = r_idx;
  assign bus.out_last  = r_last;
  assign bus.out_valid = r_valid;
  assign bus.sat_flag  = r_sat;
endmodule

// File: tb/tb_interp_add1_seq.sv
// Directed bench for interp_add1_seq with a behavioural operand-b mux.
// Expected values are hand-computed; saturation cases follow INTERP_SAT_EN.
module tb_interp_add1_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  interp_add1_seq_if bus ();

  interp_add1_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // operand-b mux driven by the sequencer select
  always_comb begin
    case (bus.sel)
      3'b001:  bus.add1_b = {{2{bus.E3[16]}}, bus.E3} << 1;
      3'b110:  bus.add1_b = {{2{bus.E1[16]}}, bus.E1};
      3'b100:  bus.add1_b = {bus.reg_2E[17], bus.reg_2E};
      3'b011:  bus.add1_b = {{2{bus.E4[16]}}, bus.E4} << 1;
      3'b000:  bus.add1_b = 19'sd1;
      default: bus.add1_b = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int e1, input int e3, input int e4);
    bus.E1_in    = 17'(e1);
    bus.E3_in    = 17'(e3);
    bus.E4_in    = 17'(e4);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.E1_in     = '0;
    bus.E3_in     = '0;
    bus.E4_in     = '0;
    bus.out_ready = 1'b0;
    #12;
    total++;
    if (bus.sel !== 3'b111) begin
      bad++;
      $display("FAIL rst_sel got=%b exp=111", bus.sel);
    end
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
      bad++;
      $display("FAIL rst_out got=%b/%0d exp=0/0",
               bus.out_valid, bus.out_data);
    end
    total++;
    if (bus.reg_2E !== '0 || bus.reg_5E !== '0 || bus.sat_flag !== 1'b0) begin
      bad++;
      $display("FAIL rst_regs got=%0d/%0d/%b exp=0/0/0",
               bus.reg_2E, bus.reg_5E, bus.sat_flag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_release got=%b/%b exp=1/0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    send(100, 10, 7);
    total++;
    if (bus.in_ready !== 1'b0 || bus.sel !== 3'b001) begin
      bad++;
      $display("FAIL t1_neg got=%b/%b exp=0/001", bus.in_ready, bus.sel);
    end
    tick();
    total++;
    if (bus.reg_2E !== -18'sd20 || bus.sel !== 3'b110) begin
      bad++;
      $display("FAIL t1_reg2e got=%0d/%b exp=-20/110", bus.reg_2E, bus.sel);
    end
    tick();
    total++;
    if (bus.reg_5E !== 19'sd500 || bus.sel !== 3'b100) begin
      bad++;
      $display("FAIL t1_reg5e got=%0d/%b exp=500/100", bus.reg_5E, bus.sel);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 19'sd480
        || bus.out_idx !== 2'd0 || bus.out_last !== 1'b0) begin
      bad++;
      $display("FAIL t1_y0 got=%b/%0d/%0d/%b exp=1/480/0/0",
               bus.out_valid, bus.out_data, bus.out_idx, bus.out_last);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 19'sd494
        || bus.out_idx !== 2'd1 || bus.out_last !== 1'b0) begin
      bad++;
      $display("FAIL t1_y1 got=%b/%0d/%0d/%b exp=1/494/1/0",
               bus.out_valid, bus.out_data, bus.out_idx, bus.out_last);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 19'sd495
        || bus.out_idx !== 2'd2 || bus.out_last !== 1'b1
        || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL t1_y2 got=%b/%0d/%0d/%b/%b exp=1/495/2/1/1",
               bus.out_valid, bus.out_data, bus.out_idx,
               bus.out_last, bus.in_ready);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL t1_drain got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b1;
    send(100, 10, 7);
    tick();
    tick();
    bus.out_ready = 1'b0;
    tick();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 19'sd480) begin
      bad++;
      $display("FAIL t2_y0 got=%b/%0d exp=1/480", bus.out_valid, bus.out_data);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (bus.out_data !== 19'sd480 || bus.sel !== 3'b011
          || bus.out_idx !== 2'd0 || bus.out_valid !== 1'b1) begin
        bad++;
        $display("FAIL t2_hold%0d got=%0d/%b/%0d exp=480/011/0",
                 i, bus.out_data, bus.sel, bus.out_idx);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    total++;
    if (bus.out_data !== 19'sd494 || bus.out_idx !== 2'd1) begin
      bad++;
      $display("FAIL t2_y1 got=%0d/%0d exp=494/1", bus.out_data, bus.out_idx);
    end
    tick();
    total++;
    if (bus.out_data !== 19'sd495 || bus.out_last !== 1'b1) begin
      bad++;
      $display("FAIL t2_y2 got=%0d/%b exp=495/1", bus.out_data, bus.out_last);
    end
    tick();
  endtask

  task automatic test_sat5e();
    int exp5;
    logic expf;
`ifdef INTERP_SAT_EN
    exp5 = 262143;
    expf = 1'b1;
`else
    exp5 = -196613;
    expf = 1'b0;
`endif
    bus.out_ready = 1'b1;
    send(65535, 0, 0);
    tick();
    tick();
    total++;
    if (bus.reg_5E !== 19'(exp5) || bus.sat_flag !== expf) begin
      bad++;
      $display("FAIL t3_sat5e got=%0d/%b exp=%0d/%b",
               bus.reg_5E, bus.sat_flag, exp5, expf);
    end
    repeat (4) tick();
  endtask

  task automatic test_sat2e();
    int exp2;
    logic expf;
`ifdef INTERP_SAT_EN
    exp2 = 131071;
    expf = 1'b1;
`else
    exp2 = -131072;
    expf = 1'b0;
`endif
    bus.out_ready = 1'b1;
    send(0, -65536, 0);
    tick();
    total++;
    if (bus.reg_2E !== 18'(exp2) || bus.sat_flag !== expf) begin
      bad++;
      $display("FAIL t4_sat2e got=%0d/%b exp=%0d/%b",
               bus.reg_2E, bus.sat_flag, exp2, expf);
    end
    repeat (5) tick();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    send(100, 10, 7);
    tick();
    tick();
    tick();
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_data !== 19'sd495 || bus.out_last !== 1'b1
        || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL t5_pend got=%0d/%b/%b exp=495/1/1",
               bus.out_data, bus.out_last, bus.in_ready);
    end
    send(20, 3, 5);
    total++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL t5_accept got=%b/%b exp=0/1", bus.in_ready, bus.out_valid);
    end
    repeat (4) tick();
    total++;
    if (bus.out_data !== 19'sd495 || bus.sel !== 3'b100
        || bus.out_idx !== 2'd2) begin
      bad++;
      $display("FAIL t5_stall got=%0d/%b/%0d exp=495/100/2",
               bus.out_data, bus.sel, bus.out_idx);
    end
    bus.out_ready = 1'b1;
    tick();
    total++;
    if (bus.out_data !== 19'sd94 || bus.out_idx !== 2'd0) begin
      bad++;
      $display("FAIL t5_y0 got=%0d/%0d exp=94/0", bus.out_data, bus.out_idx);
    end
    tick();
    total++;
    if (bus.out_data !== 19'sd104 || bus.out_idx !== 2'd1) begin
      bad++;
      $display("FAIL t5_y1 got=%0d/%0d exp=104/1", bus.out_data, bus.out_idx);
    end
    tick();
    total++;
    if (bus.out_data !== 19'sd105 || bus.out_last !== 1'b1) begin
      bad++;
      $display("FAIL t5_y2 got=%0d/%b exp=105/1", bus.out_data, bus.out_last);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL t5_drain got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b1;
    send(100, 10, 7);
    tick();
    tick();
    tick();
    bus.out_ready = 1'b0;
    total++;
    if (bus.sel !== 3'b011) begin
      bad++;
      $display("FAIL t6_inr1 got=%b exp=011", bus.sel);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.sel !== 3'b111 || bus.out_valid !== 1'b0
        || bus.out_data !== '0 || bus.reg_5E !== '0
        || bus.reg_2E !== '0 || bus.E1 !== '0) begin
      bad++;
      $display("FAIL t6_async got=%b/%b/%0d/%0d/%0d/%0d exp=111/0/0/0/0/0",
               bus.sel, bus.out_valid, bus.out_data,
               bus.reg_5E, bus.reg_2E, bus.E1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0
        || bus.sel !== 3'b111) begin
      bad++;
      $display("FAIL t6_release got=%b/%b/%b exp=1/0/111",
               bus.in_ready, bus.out_valid, bus.sel);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_sat5e();
    test_sat2e();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
